// File: rtl/sme_pkg.sv
// Shared types and widths for the SME job sequencer.
package sme_pkg;

  localparam int CHAR_W = 8;
  localparam int IDX_W  = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_STR,
    ST_SEND_PAT,
    ST_WAIT,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_BADJOB  = 2'd2
  } err_e;

endpackage

// File: rtl/sme_sequencer_if.sv
// Character bus between the sequencer and the SME string-match engine.
interface sme_sequencer_if;
  import sme_pkg::*;

  logic [CHAR_W-1:0] sme_chardata;
  logic              sme_isstring;
  logic              sme_ispattern;
  logic              sme_valid;
  logic              sme_match;
  logic [IDX_W-1:0]  sme_match_index;

  modport master (
    output sme_chardata, sme_isstring, sme_ispattern,
    input  sme_valid, sme_match, sme_match_index
  );

  modport slave (
    input  sme_chardata, sme_isstring, sme_ispattern,
    output sme_valid, sme_match, sme_match_index
  );

endinterface

// File: rtl/sme_char_buf.sv
// Append-only character buffer with length counter and sticky overflow.
// len_next/ovf_next include the write being committed this cycle so the
// sequencer can judge a job launched in the same cycle as a load.
module sme_char_buf
  import sme_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int LEN_W = $clog2(DEPTH + 1),
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              wr_first,
  input  logic [CHAR_W-1:0] wr_char,
  input  logic [AW-1:0]     rd_idx,
  output logic [CHAR_W-1:0] rd_char,
  output logic [LEN_W-1:0]  len_next,
  output logic              ovf_next
);

  logic [CHAR_W-1:0] mem_q [DEPTH];
  logic [LEN_W-1:0]  len_q, len_d;
  logic              ovf_q, ovf_d;
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;

  // First write restarts the buffer at index 0; a full buffer drops writes.
  always_comb begin
    len_d     = len_q;
    ovf_d     = ovf_q;
    mem_we    = 1'b0;
    mem_waddr = '0;
    if (wr_en) begin
      if (wr_first) begin
        mem_we = 1'b1;
        len_d  = LEN_W'(1);
        ovf_d  = 1'b0;
      end else if (len_q < LEN_W'(DEPTH)) begin
        mem_we    = 1'b1;
        mem_waddr = len_q[AW-1:0];
        len_d     = len_q + LEN_W'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // Length and overflow state.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      len_q <= len_d;
      ovf_q <= ovf_d;
    end
  end

  // Storage array; contents are only meaningful below len_q.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= wr_char;
  end

  assign rd_char  = mem_q[rd_idx];
  assign len_next = len_d;
  assign ovf_next = ovf_d;

endmodule

// File: rtl/sme_sequencer.sv
// Job sequencer: streams the buffered string and pattern into SME, waits for
// its result and reports it with a one-cycle done pulse.
//
//   state        | meaning
//   ST_IDLE      | accept loads, wait for start
//   ST_SEND_STR  | one string char per cycle to SME
//   ST_SEND_PAT  | one pattern char per cycle to SME
//   ST_WAIT      | wait for sme_valid, down-counting timeout
//   ST_DONE      | publish captured result, back to idle
module sme_sequencer
  import sme_pkg::*;
#(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic              load_sel,
  input  logic              load_first,
  input  logic [CHAR_W-1:0] load_char,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              res_match,
  output logic [IDX_W-1:0]  res_index,
  output logic [1:0]        res_err,
  sme_sequencer_if.master   sme
);

  localparam int STR_LW = $clog2(STR_MAX + 1);
  localparam int PAT_LW = $clog2(PAT_MAX + 1);
  localparam int STR_AW = $clog2(STR_MAX);
  localparam int PAT_AW = $clog2(PAT_MAX);
  localparam int WAIT_W = $clog2(TIMEOUT);

  state_e            state_q, state_d;
  logic [STR_LW-1:0] idx_q, idx_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              dirty_q, dirty_d, held_q, held_d;
  logic              cap_match_q, cap_match_d;
  logic [IDX_W-1:0]  cap_index_q, cap_index_d;
  err_e              cap_err_q, cap_err_d;
  logic [CHAR_W-1:0] chardata_q, chardata_d;
  logic              isstr_q, isstr_d, ispat_q, ispat_d;
  logic              done_q, done_d, res_match_q, res_match_d;
  logic [IDX_W-1:0]  res_index_q, res_index_d;
  err_e              res_err_q, res_err_d;

  logic              str_we, pat_we, bad_job;
  logic [STR_LW-1:0] str_len;
  logic [PAT_LW-1:0] pat_len;
  logic              str_ovf, pat_ovf;
  logic [CHAR_W-1:0] str_char, pat_char;

  assign str_we = load_en && !load_sel && (state_q == ST_IDLE);
  assign pat_we = load_en &&  load_sel && (state_q == ST_IDLE);

  sme_char_buf #(.DEPTH(STR_MAX)) u_str_buf (
    .clk(clk), .reset(reset), .wr_en(str_we), .wr_first(load_first),
    .wr_char(load_char), .rd_idx(idx_q[STR_AW-1:0]), .rd_char(str_char),
    .len_next(str_len), .ovf_next(str_ovf)
  );

  sme_char_buf #(.DEPTH(PAT_MAX)) u_pat_buf (
    .clk(clk), .reset(reset), .wr_en(pat_we), .wr_first(load_first),
    .wr_char(load_char), .rd_idx(idx_q[PAT_AW-1:0]), .rd_char(pat_char),
    .len_next(pat_len), .ovf_next(pat_ovf)
  );

  assign bad_job = (pat_len == '0) || str_ovf || pat_ovf ||
                   ((str_len == '0) && !held_d);

  // Next-state, string bookkeeping and result capture.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wait_d      = wait_q;
    dirty_d     = dirty_q;
    held_d      = held_q;
    cap_match_d = cap_match_q;
    cap_index_d = cap_index_q;
    cap_err_d   = cap_err_q;
    if (str_we) begin
      dirty_d = 1'b1;
      if (load_first) held_d = 1'b0;
    end
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d = '0;
          if (bad_job) begin
            state_d     = ST_DONE;
            cap_match_d = 1'b0;
            cap_index_d = '0;
            cap_err_d   = ERR_BADJOB;
          end else if (dirty_d) begin
            state_d = ST_SEND_STR;
          end else begin
            state_d = ST_SEND_PAT;
          end
        end
      end
      ST_SEND_STR: begin
        idx_d = idx_q + STR_LW'(1);
        if (idx_q == str_len - STR_LW'(1)) begin
          idx_d   = '0;
          state_d = ST_SEND_PAT;
          dirty_d = 1'b0;
          held_d  = 1'b1;
        end
      end
      ST_SEND_PAT: begin
        idx_d = idx_q + STR_LW'(1);
        if (idx_q == STR_LW'(pat_len) - STR_LW'(1)) begin
          idx_d   = '0;
          state_d = ST_WAIT;
          wait_d  = WAIT_W'(TIMEOUT - 1);
        end
      end
      ST_WAIT: begin
        if (sme.sme_valid) begin
          state_d     = ST_DONE;
          cap_match_d = sme.sme_match;
          cap_index_d = sme.sme_match_index;
          cap_err_d   = ERR_NONE;
        end else if (wait_q == '0) begin
          state_d     = ST_DONE;
          cap_match_d = 1'b0;
          cap_index_d = '0;
          cap_err_d   = ERR_TIMEOUT;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered SME bus and host results, one cycle behind the FSM state.
  always_comb begin
    chardata_d  = '0;
    isstr_d     = 1'b0;
    ispat_d     = 1'b0;
    done_d      = (state_q == ST_DONE);
    res_match_d = res_match_q;
    res_index_d = res_index_q;
    res_err_d   = res_err_q;
    if (state_q == ST_SEND_STR) begin
      chardata_d = str_char;
      isstr_d    = 1'b1;
    end
    if (state_q == ST_SEND_PAT) begin
      chardata_d = pat_char;
      ispat_d    = 1'b1;
    end
    if (state_q == ST_DONE) begin
      res_match_d = cap_match_q;
      res_index_d = cap_index_q;
      res_err_d   = cap_err_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      wait_q      <= '0;
      dirty_q     <= 1'b0;
      held_q      <= 1'b0;
      cap_match_q <= 1'b0;
      cap_index_q <= '0;
      cap_err_q   <= ERR_NONE;
      chardata_q  <= '0;
      isstr_q     <= 1'b0;
      ispat_q     <= 1'b0;
      done_q      <= 1'b0;
      res_match_q <= 1'b0;
      res_index_q <= '0;
      res_err_q   <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wait_q      <= wait_d;
      dirty_q     <= dirty_d;
      held_q      <= held_d;
      cap_match_q <= cap_match_d;
      cap_index_q <= cap_index_d;
      cap_err_q   <= cap_err_d;
      chardata_q  <= chardata_d;
      isstr_q     <= isstr_d;
      ispat_q     <= ispat_d;
      done_q      <= done_d;
      res_match_q <= res_match_d;
      res_index_q <= res_index_d;
      res_err_q   <= res_err_d;
    end
  end

  assign busy              = (state_q != ST_IDLE);
  assign done              = done_q;
  assign res_match         = res_match_q;
  assign res_index         = res_index_q;
  assign res_err           = res_err_q;
  assign sme.sme_chardata  = chardata_q;
  assign sme.sme_isstring  = isstr_q;
  assign sme.sme_ispattern = ispat_q;

endmodule
